// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: FIFO pop/readout and sticky error status.
interface uart_rx_if;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rx_valid, frame_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rx_valid, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1) with a small first-word-fall-through FIFO
// and sticky framing/overrun flags.
module uart_rx #(
  parameter int TICK_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk_in,
  input  logic      sys_rstn,
  input  logic      uart_rxd,
  uart_rx_if.slave  rx_if
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW:0]     CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic [15:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            rxd_s, fall, tick;
  logic            push_req, ferr_evt, push, pop, empty, full;

  // Synchronizer plus one extra stage for falling-edge detection; idle-high reset.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rxd_s = sync2_q;
  assign fall  = sync3_q & ~sync2_q;
  assign tick  = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Frame FSM; the tick phase is realigned at start detection so every
  // sample lands a fixed number of ticks after the edge.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 16'd1;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push_req   = 1'b0;
    ferr_evt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          cnt_d      = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (!rxd_s) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d   = '0;
            shift_d = {rxd_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_d = S_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (cnt_q == 4'd15) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            if (rxd_s) push_req = 1'b1;
            else       ferr_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign pop   = rx_if.rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push  = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (rx_if.err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (ferr_evt)                  frame_err_d = 1'b1;
    if (push_req && full && !pop)  overrun_d   = 1'b1;
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_if.rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_if.rx_valid  = ~empty;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model (byte queue + scheduled stop samples)
// checked against the DUT every cycle, plus literal checkpoints.
module tb_uart_rx;

  localparam int TD    = 4;
  localparam int DEPTH = 4;
  localparam int BITC  = 16 * TD;
  // Edge seen 3 clocks after the line drops; stop sampled 8 + 9*16 ticks later.
  localparam int STOP_LAT = 3 + TD * (8 + 9 * 16);

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         good;
  } ev_t;

  logic clk_in   = 1'b0;
  logic sys_rstn = 1'b0;
  logic uart_rxd = 1'b1;

  uart_rx_if rif();

  uart_rx #(.TICK_DIV(TD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .uart_rxd (uart_rxd),
    .rx_if    (rif)
  );

  always #5 clk_in = ~clk_in;

  ev_t        sq[$];
  logic [7:0] mq[$];
  bit         m_ferr, m_ovr;
  int         cyc   = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a FIFO of bytes fed by stop-sample events computed from frame start times.
  task automatic model_step();
    bit pop_c, full_b, evp, evf;
    logic [7:0] evb;
    cyc++;
    if (!sys_rstn) begin
      mq.delete();
      sq.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      evp = 1'b0;
      evf = 1'b0;
      evb = 8'h00;
      while (sq.size() > 0 && sq[0].at <= cyc) begin
        if (sq[0].good) begin
          evp = 1'b1;
          evb = sq[0].b;
        end else begin
          evf = 1'b1;
        end
        void'(sq.pop_front());
      end
      pop_c  = rif.rd_en && (mq.size() > 0);
      full_b = (mq.size() == DEPTH);
      if (rif.err_clr) begin
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      if (evf) m_ferr = 1'b1;
      if (pop_c) void'(mq.pop_front());
      if (evp) begin
        if (full_b && !pop_c) m_ovr = 1'b1;
        else                  mq.push_back(evb);
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_d;
    logic       e_v, e_f, e_o;
    if (!sys_rstn) begin
      e_d = 8'h00; e_v = 1'b0; e_f = 1'b0; e_o = 1'b0;
    end else begin
      e_v = (mq.size() > 0);
      e_d = e_v ? mq[0] : 8'h00;
      e_f = m_ferr;
      e_o = m_ovr;
    end
    chk("rx_valid",  {7'd0, rif.rx_valid},  {7'd0, e_v});
    chk("rd_data",   rif.rd_data,           e_d);
    chk("frame_err", {7'd0, rif.frame_err}, {7'd0, e_f});
    chk("overrun",   {7'd0, rif.overrun},   {7'd0, e_o});
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  initial forever begin
    @(negedge clk_in);
    check_outputs();
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    ev_t e;
    e.at   = cyc + STOP_LAT;
    e.b    = b;
    e.good = stop_bit;
    sq.push_back(e);
    uart_rxd = 1'b0;
    repeat (BITC) step();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BITC) step();
    end
    uart_rxd = stop_bit;
    repeat (BITC) step();
    uart_rxd = 1'b1;
  endtask

  task automatic pop_one();
    rif.rd_en = 1'b1;
    step();
    rif.rd_en = 1'b0;
  endtask

  logic [7:0] vals [5];
  logic [7:0] abort_b;

  initial begin
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    abort_b = 8'hC3;
    rif.rd_en   = 1'b0;
    rif.err_clr = 1'b0;

    // Reset and long idle
    repeat (300) step();
    sys_rstn = 1'b1;
    repeat (1000) step();
    chk("idle rx_valid", {7'd0, rif.rx_valid}, 8'd0);
    chk("idle rd_data",  rif.rd_data,          8'h00);
    chk("idle ferr",     {7'd0, rif.frame_err}, 8'd0);
    chk("idle ovr",      {7'd0, rif.overrun},   8'd0);

    // Good frame, then pop
    send_frame(8'hA5, 1'b1);
    chk("A5 valid", {7'd0, rif.rx_valid}, 8'd1);
    chk("A5 data",  rif.rd_data,          8'hA5);
    pop_one();
    chk("A5 popped valid", {7'd0, rif.rx_valid}, 8'd0);
    chk("A5 popped data",  rif.rd_data,          8'h00);

    // Start-bit glitch
    uart_rxd = 1'b0;
    repeat (12) step();
    uart_rxd = 1'b1;
    repeat (100) step();
    chk("glitch valid", {7'd0, rif.rx_valid},  8'd0);
    chk("glitch ferr",  {7'd0, rif.frame_err}, 8'd0);

    // Framing error, clear, then good frame
    send_frame(8'h3C, 1'b0);
    chk("3C ferr",  {7'd0, rif.frame_err}, 8'd1);
    chk("3C valid", {7'd0, rif.rx_valid},  8'd0);
    rif.err_clr = 1'b1;
    step();
    rif.err_clr = 1'b0;
    chk("err_clr ferr", {7'd0, rif.frame_err}, 8'd0);
    repeat (20) step();
    send_frame(8'h5A, 1'b1);
    chk("5A data", rif.rd_data,           8'h5A);
    chk("5A ferr", {7'd0, rif.frame_err}, 8'd0);
    pop_one();

    // Overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_frame(vals[i], 1'b1);
    chk("ovr set", {7'd0, rif.overrun}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr pop%0d", i), rif.rd_data, vals[i]);
      pop_one();
    end
    chk("ovr drained valid", {7'd0, rif.rx_valid}, 8'd0);

    // Reset during data bit 3
    repeat (20) step();
    uart_rxd = 1'b0;
    repeat (BITC) step();
    for (int i = 0; i < 3; i++) begin
      uart_rxd = abort_b[i];
      repeat (BITC) step();
    end
    uart_rxd = abort_b[3];
    repeat (BITC / 2) step();
    chk("pre-reset ovr", {7'd0, rif.overrun}, 8'd1);
    sys_rstn = 1'b0;
    #1;
    chk("mid rst valid", {7'd0, rif.rx_valid},  8'd0);
    chk("mid rst data",  rif.rd_data,           8'h00);
    chk("mid rst ferr",  {7'd0, rif.frame_err}, 8'd0);
    chk("mid rst ovr",   {7'd0, rif.overrun},   8'd0);
    uart_rxd = 1'b1;
    repeat (20) step();
    sys_rstn = 1'b1;
    repeat (50) step();
    send_frame(8'h7E, 1'b1);
    chk("7E data", rif.rd_data,           8'h7E);
    chk("7E ferr", {7'd0, rif.frame_err}, 8'd0);
    chk("7E ovr",  {7'd0, rif.overrun},   8'd0);
    pop_one();
    chk("7E popped valid", {7'd0, rif.rx_valid}, 8'd0);

    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter TICK_DIV, default 27: clk_in cycles per oversample tick (16 ticks per bit); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, 2..16.
REQ-003 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 sys_rstn  input  1  reset, asynchronous, active-low.
REQ-005 uart_rxd  input  1  serial line, idle high, asynchronous to clk_in.
REQ-006 rd_en  input  1  consumer pop request for the FIFO head.
REQ-007 err_clr  input  1  clears both sticky error flags.
REQ-008 rd_data  output  8  FIFO head byte, first-word-fall-through.
REQ-009 rx_valid  output  1  FIFO non-empty; rd_data is valid.
REQ-010 frame_err  output  1  sticky: a stop bit sampled low.
REQ-011 overrun  output  1  sticky: a good byte was dropped because the FIFO was full.

Function
REQ-012 uart_rxd SHALL pass a 2-flop synchronizer; both stages reset to 1. A third registered copy provides falling-edge detection.
REQ-013 Tick generator: a counter 0..TICK_DIV-1 SHALL emit a one-cycle tick at terminal count and wrap to 0. It free-runs except when forced to 0 on IDLE->START.
REQ-014 Bit-phase counter cnt (4 bits) SHALL advance on ticks only. It SHALL be cleared on each state entry and after each sample.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on a synchronized falling edge (previous 1, current 0). A level-low line alone SHALL NOT start a frame.
REQ-017 START: at cnt==7 the line SHALL be sampled. 0 -> DATA with bit index 0; 1 -> IDLE (glitch rejected, nothing recorded).
REQ-018 DATA: at cnt==15 the line SHALL be sampled into the shift register, LSB first. After bit index 7 is sampled -> STOP.
REQ-019 STOP: at cnt==15 the line SHALL be sampled. 1 -> push byte; 0 -> set frame_err and discard byte. Both outcomes -> IDLE in the same cycle.
REQ-020 A pushed byte SHALL appear on rd_data with rx_valid=1 in the cycle after the stop sample.
REQ-021 Pop: rd_en while rx_valid=1 SHALL remove the head at the clock edge. rd_en while empty SHALL be ignored.
REQ-022 Push while full, without a simultaneous pop: the new byte SHALL be dropped and overrun set; existing contents are unchanged.
REQ-023 Push and pop in the same cycle SHALL both take effect; when full this causes no overrun and the count is unchanged.
REQ-024 FIFO order SHALL be strict FIFO. Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a count register of width log2(FIFO_DEPTH)+1.
REQ-025 err_clr SHALL clear frame_err and overrun. If a set event occurs in the same cycle, set wins.
REQ-026 rd_data SHALL be 8'h00 when the FIFO is empty.

Reset
REQ-027 sys_rstn low SHALL immediately set the following, regardless of the clock:
  - FSM to IDLE; all counters and pointers to 0;
  - shift register, rd_data, rx_valid, frame_err and overrun to 0;
  - synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL abandon the frame without a push or error. After release, the next falling edge SHALL start a fresh frame.

Verification (TICK_DIV=4, so 1 bit = 64 clk_in cycles)
REQ-029 Reset: uart_rxd=1, sys_rstn low 300 clocks then high -> rx_valid=0, rd_data=00, frame_err=0, overrun=0 for 1000 clocks.
REQ-030 Frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> rx_valid=1 and rd_data=A5 one cycle after the stop sample. A one-cycle rd_en pulse -> rx_valid=0, rd_data=00.
REQ-031 Glitch: uart_rxd low 12 clocks (3 ticks), then high -> no push, frame_err=0, FSM back to IDLE.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err=1, rx_valid=0. A single err_clr pulse -> frame_err=0. A following good 0x5A is received correctly.
REQ-033 Five back-to-back frames 11,22,33,44,55 with no reads -> overrun=1. Four pops return 11,22,33,44, then rx_valid=0.
REQ-034 Assert sys_rstn low during data bit 3 of a frame -> all outputs 0. After release, a frame 0x7E yields rd_data=7E and no errors.
